// File: rtl/round_robin_dispatch_if.sv
// Upstream beat stream plus per-lane downstream handshake for round_robin_dispatch.
// master: the dispatcher's view; slave: the surrounding producer/lane environment.
interface round_robin_dispatch_if #(
    parameter int unsigned LANE_NB = 4,
    parameter int unsigned DATA_W  = 16
);
    logic               s_valid;
    logic               s_ready;
    logic [DATA_W-1:0]  s_data;
    logic               s_last;
    logic [LANE_NB-1:0] lane_avail;
    logic [LANE_NB-1:0] m_valid;
    logic [LANE_NB-1:0] m_ready;
    logic [DATA_W-1:0]  m_data;
    logic               m_last;

    modport master (
        input  s_valid, s_data, s_last, lane_avail, m_ready,
        output s_ready, m_valid, m_data, m_last
    );

    modport slave (
        output s_valid, s_data, s_last, lane_avail, m_ready,
        input  s_ready, m_valid, m_data, m_last
    );
endinterface

// File: rtl/round_robin_dispatch.sv
// 1->N frame dispatcher: picks the next free lane round-robin and holds it for a whole frame.
// Optional frame counter on frm_cnt_o enabled by defining RR_DISPATCH_CNT_EN.
module round_robin_dispatch #(
    parameter int unsigned LANE_NB = 4,
    parameter int unsigned DATA_W  = 16
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    round_robin_dispatch_if.master bus,
    output logic [15:0]            frm_cnt_o
);
    typedef enum logic {IDLE, LOCK} state_e;

    state_e             state_q, state_d;
    logic [LANE_NB-1:0] mask_q, mask_d;
    logic [LANE_NB-1:0] lock_q, lock_d;

    logic               out_vld;
    logic [LANE_NB-1:0] out_lane;
    logic [DATA_W-1:0]  out_data;
    logic               out_last;

    logic               slot_free, m_hs, s_hs, s_rdy;
    logic [LANE_NB-1:0] cand, pick, sel_oh, mask_above, load_lane;
    int unsigned        sel_idx;

    assign m_hs      = out_vld & |(bus.m_ready & out_lane);
    assign slot_free = ~out_vld | m_hs;

    // Prefer lanes above the last one served; fall back to the lowest available lane.
    always_comb begin : lane_select
        cand       = bus.lane_avail & mask_q;
        pick       = (cand != '0) ? cand : bus.lane_avail;
        sel_idx    = 0;
        sel_oh     = '0;
        mask_above = '0;
        for (int unsigned i = LANE_NB; i > 0; i--) begin
            if (pick[i-1]) sel_idx = i - 1;
        end
        for (int unsigned i = 0; i < LANE_NB; i++) begin
            sel_oh[i]     = (i == sel_idx);
            mask_above[i] = (i > sel_idx) || (sel_idx == LANE_NB - 1);
        end
    end

    always_comb begin : fsm_next
        state_d   = state_q;
        mask_d    = mask_q;
        lock_d    = lock_q;
        s_rdy     = 1'b0;
        s_hs      = 1'b0;
        load_lane = lock_q;
        case (state_q)
            IDLE: begin
                s_rdy     = slot_free & |bus.lane_avail;
                s_hs      = bus.s_valid & s_rdy;
                load_lane = sel_oh;
                if (s_hs) begin
                    mask_d = mask_above;
                    if (!bus.s_last) begin
                        state_d = LOCK;
                        lock_d  = sel_oh;
                    end
                end
            end
            LOCK: begin
                s_rdy = slot_free;
                s_hs  = bus.s_valid & s_rdy;
                if (s_hs && bus.s_last) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            mask_q  <= '1;
            lock_q  <= '0;
        end else begin
            state_q <= state_d;
            mask_q  <= mask_d;
            lock_q  <= lock_d;
        end
    end

    // A new beat may overwrite the slice on the same edge its previous beat drains.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            out_vld  <= 1'b0;
            out_lane <= '0;
            out_data <= '0;
            out_last <= 1'b0;
        end else if (s_hs) begin
            out_vld  <= 1'b1;
            out_lane <= load_lane;
            out_data <= bus.s_data;
            out_last <= bus.s_last;
        end else if (m_hs) begin
            out_vld  <= 1'b0;
        end
    end

    assign bus.s_ready = s_rdy;
    assign bus.m_valid = out_lane & {LANE_NB{out_vld}};
    assign bus.m_data  = out_data;
    assign bus.m_last  = out_last;

`ifdef RR_DISPATCH_CNT_EN
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni)                  frm_cnt_o <= '0;
        else if (s_hs && bus.s_last)  frm_cnt_o <= frm_cnt_o + 16'd1;
    end
`else
    assign frm_cnt_o = '0;
`endif
endmodule

// File: tb/tb_round_robin_dispatch.sv
// Scoreboard bench for round_robin_dispatch: expected beats queued at upstream handshake,
// popped and compared at each downstream handshake.
module tb_round_robin_dispatch;
    localparam int unsigned LANE_NB = 4;
    localparam int unsigned DATA_W  = 16;

    typedef struct {
        int unsigned       lane;
        logic [DATA_W-1:0] data;
        logic              last;
    } beat_t;

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic [15:0] frm_cnt_o;

    round_robin_dispatch_if #(.LANE_NB(LANE_NB), .DATA_W(DATA_W)) bus ();

    round_robin_dispatch #(.LANE_NB(LANE_NB), .DATA_W(DATA_W)) dut (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .bus       (bus),
        .frm_cnt_o (frm_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    beat_t        sb[$];
    int           n_checks = 0;
    int           n_fail = 0;
    int unsigned  frames_done = 0;
    int unsigned  cur_lane = 0;
    int           hold_cnt = 0;
    bit           hold_ref_v = 1'b0;
    logic [15:0]  hold_ref = '0;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] exp_cnt();
`ifdef RR_DISPATCH_CNT_EN
        return 16'(frames_done);
`else
        return 16'h0000;
`endif
    endfunction

    // One clock: settle, apply stall release, record upstream handshake, score downstream handshake.
    task automatic cycle(output bit hs);
        beat_t e;
        #1;
        if (hold_cnt > 0 && bus.m_valid != '0) begin
            check_eq("stall_s_ready", 32'(bus.s_ready), 32'd0);
            if (!hold_ref_v) begin
                hold_ref   = bus.m_data;
                hold_ref_v = 1'b1;
            end else begin
                check_eq("stall_m_data", 32'(bus.m_data), 32'(hold_ref));
            end
            hold_cnt--;
            if (hold_cnt == 0) bus.m_ready = '1;
            #1;
        end
        hs = bus.s_valid && bus.s_ready;
        if (hs) begin
            sb.push_back('{cur_lane, bus.s_data, bus.s_last});
            if (bus.s_last) frames_done++;
        end
        for (int k = 0; k < int'(LANE_NB); k++) begin
            if (bus.m_valid[k] && bus.m_ready[k]) begin
                if (sb.size() == 0) begin
                    check_eq("sb_underflow", 32'(sb.size()), 32'd1);
                end else begin
                    e = sb.pop_front();
                    check_eq("m_lane", 32'(k), 32'(e.lane));
                    check_eq("m_data", 32'(bus.m_data), 32'(e.data));
                    check_eq("m_last", 32'(bus.m_last), 32'(e.last));
                end
            end
        end
        if (bus.m_valid != '0) check_eq("m_onehot", 32'($countones(bus.m_valid)), 32'd1);
        @(posedge clk_i);
        #1;
    endtask

    task automatic send_frame(input int n, input int unsigned lane, input bit end_last,
                              input int unsigned base, output int stalls);
        bit hs;
        int waited;
        stalls   = 0;
        cur_lane = lane;
        for (int b = 0; b < n; b++) begin
            bus.s_valid = 1'b1;
            bus.s_data  = 16'(base + 32'(b));
            bus.s_last  = end_last && (b == n - 1);
            hs = 1'b0;
            waited = 0;
            while (!hs && waited < 50) begin
                cycle(hs);
                waited++;
            end
            if (!hs) begin
                check_eq("beat_timeout", 32'(hs), 32'd1);
                bus.s_valid = 1'b0;
                return;
            end
            stalls += waited - 1;
        end
    endtask

    task automatic idle(input int n);
        bit hs;
        bus.s_valid = 1'b0;
        bus.s_last  = 1'b0;
        for (int i = 0; i < n; i++) cycle(hs);
    endtask

    task automatic do_reset();
        bus.s_valid    = 1'b0;
        bus.s_data     = '0;
        bus.s_last     = 1'b0;
        bus.lane_avail = '0;
        bus.m_ready    = '1;
        rst_ni         = 1'b0;
        sb.delete();
        frames_done    = 0;
        repeat (2) @(posedge clk_i);
        #1;
        check_eq("rst_m_valid", 32'(bus.m_valid), 32'd0);
        check_eq("rst_m_data", 32'(bus.m_data), 32'd0);
        check_eq("rst_m_last", 32'(bus.m_last), 32'd0);
        check_eq("rst_frm_cnt", 32'(frm_cnt_o), 32'd0);
        check_eq("rst_s_ready", 32'(bus.s_ready), 32'd0);
        @(negedge clk_i);
        rst_ni = 1'b1;
        @(posedge clk_i);
        #1;
    endtask

    initial begin
        int st;
        bit hs;
        int unsigned t1_lanes[5] = '{0, 1, 2, 3, 0};
        int unsigned t2_lanes[4] = '{0, 2, 3, 0};

        do_reset();

        // 1: single-beat frames rotate over all lanes
        bus.lane_avail = 4'b1111;
        foreach (t1_lanes[i]) begin
            send_frame(1, t1_lanes[i], 1'b1, 32'h100 + 32'(i), st);
            check_eq("t1_no_stall", 32'(st), 32'd0);
        end
        bus.s_valid = 1'b0;
        check_eq("t1_latency", 32'(bus.m_valid), 32'b0001);
        idle(2);
        check_eq("t1_frm_cnt", 32'(frm_cnt_o), 32'(exp_cnt()));

        // 2: lane 1 unavailable, 3-beat frames back-to-back
        do_reset();
        bus.lane_avail = 4'b1101;
        foreach (t2_lanes[i]) begin
            send_frame(3, t2_lanes[i], 1'b1, 32'h200 + 32'(i) * 16, st);
            check_eq("t2_no_stall", 32'(st), 32'd0);
        end
        idle(2);

        // 3: lane 1 back-pressure mid-frame
        bus.lane_avail = 4'b1111;
        bus.m_ready    = 4'b1101;
        hold_cnt       = 5;
        hold_ref_v     = 1'b0;
        send_frame(4, 1, 1'b1, 32'h300, st);
        check_eq("t3_stalls", 32'(st), 32'd4);
        idle(2);
        check_eq("t3_frm_cnt", 32'(frm_cnt_o), 32'(exp_cnt()));

        // 4: no lane available, then only lane 2; following frame proves mask moved above lane 2
        bus.lane_avail = 4'b0000;
        bus.s_valid    = 1'b1;
        bus.s_data     = 16'hDEAD;
        bus.s_last     = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            check_eq("t4_no_ready", 32'(bus.s_ready), 32'd0);
            cycle(hs);
        end
        bus.lane_avail = 4'b0100;
        send_frame(1, 2, 1'b1, 32'h400, st);
        bus.lane_avail = 4'b1111;
        send_frame(1, 3, 1'b1, 32'h410, st);
        idle(2);

        // 5: reset in the middle of a frame on lane 3
        bus.lane_avail = 4'b1000;
        send_frame(2, 3, 1'b0, 32'h500, st);
        bus.s_valid = 1'b0;
        #1;
        check_eq("t5_pre_valid", 32'(bus.m_valid), 32'b1000);
        #2;
        rst_ni = 1'b0;
        #1;
        check_eq("t5_async_valid", 32'(bus.m_valid), 32'd0);
        sb.delete();
        frames_done = 0;
        @(negedge clk_i);
        rst_ni = 1'b1;
        @(posedge clk_i);
        #1;
        bus.lane_avail = 4'b1111;
        send_frame(1, 0, 1'b1, 32'h510, st);
        idle(2);
        check_eq("t5_frm_cnt", 32'(frm_cnt_o), 32'(exp_cnt()));

`ifdef RR_DISPATCH_CNT_EN
        // 6: counter wraps after 65536 frames
        do_reset();
        bus.lane_avail = 4'b1111;
        for (int i = 0; i < 65537; i++) begin
            send_frame(1, 32'(i % 4), 1'b1, 32'(i), st);
        end
        idle(2);
        check_eq("t6_frm_wrap", 32'(frm_cnt_o), 32'd1);
`else
        check_eq("t6_frm_tied", 32'(frm_cnt_o), 32'd0);
`endif

        check_eq("sb_drained", 32'(sb.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
